aibcr3_dll_lock_qual: RTL and testbench

- Parametrised, multi-channel DLL lock qualifier for the AIB DLL/DCC path.
- Per channel: synchronises a raw DLL lock into clk_dcd and requires the lock to hold for a programmable number of cycles before declaring done.
- Filters short lock drop-outs and flags real lock loss with a sticky bit.
- Aggregates enabled channels into a single dcc_done; rb_cont_cal masks the lock outputs during continuous calibration.

---
 rtl/aibcr3_dll_lock_qual_if.sv | 30 +++
 rtl/aibcr3_dll_lock_qual.sv | 213 +++++++++++++++++++++
 tb/tb_aibcr3_dll_lock_qual.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aibcr3_dll_lock_qual_if.sv
// Bundle of the DLL lock qualifier's data/control signals.
//   master : the block's environment (drives raw lock, enables, trims, clr_lost;
//            observes dll_lock_reg, ch_done, dcc_done, lock_lost)
//   slave  : the lock qualifier itself
interface aibcr3_dll_lock_qual_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int FLT_W  = 4
);
    logic [NUM_CH-1:0] dll_lock_mux;
    logic [NUM_CH-1:0] ch_en;
    logic [CNT_W-1:0]  rb_lock_dly;
    logic [FLT_W-1:0]  rb_unlock_flt;
    logic              rb_cont_cal;
    logic              clr_lost;
    logic [NUM_CH-1:0] dll_lock_reg;
    logic [NUM_CH-1:0] ch_done;
    logic              dcc_done;
    logic [NUM_CH-1:0] lock_lost;

    modport master (
        output dll_lock_mux, ch_en, rb_lock_dly, rb_unlock_flt, rb_cont_cal, clr_lost,
        input  dll_lock_reg, ch_done, dcc_done, lock_lost
    );

    modport slave (
        input  dll_lock_mux, ch_en, rb_lock_dly, rb_unlock_flt, rb_cont_cal, clr_lost,
        output dll_lock_reg, ch_done, dcc_done, lock_lost
    );
endinterface

// File: rtl/aibcr3_dll_lock_qual.sv
// Multi-channel DLL lock qualifier.
// Each channel synchronises its raw DLL lock into clk_dcd, requires the lock to
// stay high for max(rb_lock_dly,1) sampled cycles before reporting ch_done, and
// tolerates lock drop-outs shorter than rb_unlock_flt+1 sampled cycles. A real
// loss sets a sticky lock_lost bit. dcc_done aggregates all enabled channels.
// Ports:
//   clk_dcd : DCD clock, all state on the rising edge
//   RST     : synchronous active-high reset
//   bus     : slave side of aibcr3_dll_lock_qual_if (lock inputs, trims, status)
module aibcr3_dll_lock_qual #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int FLT_W       = 4
) (
    input  logic                   clk_dcd,
    input  logic                   RST,
    aibcr3_dll_lock_qual_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FILT   = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [NUM_CH-1:0]      lk_s;

    state_e                 state_q [NUM_CH];
    state_e                 state_d [NUM_CH];
    logic [CNT_W-1:0]       cnt_q   [NUM_CH];
    logic [CNT_W-1:0]       cnt_d   [NUM_CH];
    logic [FLT_W-1:0]       fcnt_q  [NUM_CH];
    logic [FLT_W-1:0]       fcnt_d  [NUM_CH];

    logic [CNT_W-1:0]       thr_s;
    logic [NUM_CH-1:0]      done_s;
    logic [NUM_CH-1:0]      lost_set_s;

    logic [NUM_CH-1:0]      ch_done_q;
    logic [NUM_CH-1:0]      lock_lost_q;
    logic [NUM_CH-1:0]      lock_lost_d;
    logic [NUM_CH-1:0]      dll_lock_reg_q;
    logic                   dcc_done_q;

    // Synchronised lock is the last stage of each channel's flop chain.
    always_comb begin
        lk_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            lk_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // A programmed threshold of zero behaves like one.
    always_comb begin
        if (bus.rb_lock_dly == {CNT_W{1'b0}}) begin
            thr_s = CNT_W'(1);
        end else begin
            thr_s = bus.rb_lock_dly;
        end
    end

    // Per-channel qualification / glitch-filter next-state logic.
    always_comb begin
        logic [CNT_W:0] cnt_inc;
        cnt_inc    = {(CNT_W+1){1'b0}};
        lost_set_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            fcnt_d[i]  = fcnt_q[i];
            // One bit wider so the compare cannot wrap at the top of the range.
            cnt_inc    = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
            if (!bus.ch_en[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = {CNT_W{1'b0}};
                fcnt_d[i]  = {FLT_W{1'b0}};
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (lk_s[i]) begin
                            cnt_d[i] = CNT_W'(1);
                            if (thr_s == CNT_W'(1)) begin
                                state_d[i] = ST_LOCKED;
                            end else begin
                                state_d[i] = ST_QUAL;
                            end
                        end else begin
                            cnt_d[i] = {CNT_W{1'b0}};
                        end
                    end
                    ST_QUAL: begin
                        if (lk_s[i]) begin
                            cnt_d[i] = cnt_inc[CNT_W-1:0];
                            if (cnt_inc >= {1'b0, thr_s}) begin
                                state_d[i] = ST_LOCKED;
                            end else begin
                                state_d[i] = ST_QUAL;
                            end
                        end else begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = {CNT_W{1'b0}};
                        end
                    end
                    ST_LOCKED: begin
                        if (lk_s[i]) begin
                            state_d[i] = ST_LOCKED;
                        end else if (bus.rb_unlock_flt != {FLT_W{1'b0}}) begin
                            state_d[i] = ST_FILT;
                            fcnt_d[i]  = FLT_W'(1);
                        end else begin
                            state_d[i]    = ST_IDLE;
                            cnt_d[i]      = {CNT_W{1'b0}};
                            lost_set_s[i] = 1'b1;
                        end
                    end
                    ST_FILT: begin
                        if (lk_s[i]) begin
                            state_d[i] = ST_LOCKED;
                            fcnt_d[i]  = {FLT_W{1'b0}};
                        end else if (fcnt_q[i] >= bus.rb_unlock_flt) begin
                            state_d[i]    = ST_IDLE;
                            cnt_d[i]      = {CNT_W{1'b0}};
                            fcnt_d[i]     = {FLT_W{1'b0}};
                            lost_set_s[i] = 1'b1;
                        end else begin
                            fcnt_d[i] = fcnt_q[i] + FLT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = {CNT_W{1'b0}};
                        fcnt_d[i]  = {FLT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // ch_done decode of the next state; the filter state still counts as done.
    always_comb begin
        done_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            done_s[i] = (state_d[i] == ST_LOCKED) || (state_d[i] == ST_FILT);
        end
    end

    // Sticky loss flag: a new loss wins over a same-edge clear; disabled channels hold.
    always_comb begin
        lock_lost_d = lock_lost_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!bus.ch_en[i]) begin
                lock_lost_d[i] = lock_lost_q[i];
            end else if (lost_set_s[i]) begin
                lock_lost_d[i] = 1'b1;
            end else if (bus.clr_lost) begin
                lock_lost_d[i] = 1'b0;
            end else begin
                lock_lost_d[i] = lock_lost_q[i];
            end
        end
    end

    // Lock synchroniser chains.
    always_ff @(posedge clk_dcd) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (RST) begin
                sync_q[i] <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.dll_lock_mux[i]};
            end
        end
    end

    // Per-channel FSM state and counters.
    always_ff @(posedge clk_dcd) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (RST) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= {CNT_W{1'b0}};
                fcnt_q[i]  <= {FLT_W{1'b0}};
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                fcnt_q[i]  <= fcnt_d[i];
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk_dcd) begin
        if (RST) begin
            ch_done_q      <= {NUM_CH{1'b0}};
            lock_lost_q    <= {NUM_CH{1'b0}};
            dll_lock_reg_q <= {NUM_CH{1'b0}};
            dcc_done_q     <= 1'b0;
        end else begin
            ch_done_q      <= done_s;
            lock_lost_q    <= lock_lost_d;
            dll_lock_reg_q <= lk_s & ~{NUM_CH{bus.rb_cont_cal}};
            // Uses the registered ch_done, so dcc_done trails it by one edge.
            dcc_done_q     <= (|bus.ch_en) & (&(ch_done_q | ~bus.ch_en));
        end
    end

    assign bus.ch_done      = ch_done_q;
    assign bus.lock_lost    = lock_lost_q;
    assign bus.dll_lock_reg = dll_lock_reg_q;
    assign bus.dcc_done     = dcc_done_q;

endmodule

// File: tb/tb_aibcr3_dll_lock_qual.sv
// Bench for aibcr3_dll_lock_qual: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a run-length
// reference model.
module tb_aibcr3_dll_lock_qual;
    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int CNT_W  = 8;
    localparam int FLT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aibcr3_dll_lock_qual_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FLT_W(FLT_W)) bus ();

    aibcr3_dll_lock_qual #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .FLT_W(FLT_W)
    ) u_dut (
        .clk_dcd (clk),
        .RST     (rst),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw lock is seen by the qualifier SYNC edges after it was sampled (queue delay).
    // Each channel counts consecutive high samples while unqualified and
    // consecutive low samples while qualified.
    logic [NUM_CH-1:0] raw_hist [$];
    int                m_run  [NUM_CH];
    int                m_lows [NUM_CH];
    logic [NUM_CH-1:0] m_done = '0;
    logic [NUM_CH-1:0] m_lost = '0;
    logic [NUM_CH-1:0] m_reg  = '0;
    logic              m_dcc  = 1'b0;
    bit                model_ok = 1'b0;

    always @(posedge clk) begin : model
        logic [NUM_CH-1:0] lk;
        int thr;
        if (rst) begin
            raw_hist.delete();
            for (int s = 0; s < SYNC; s++) raw_hist.push_back('0);
            for (int i = 0; i < NUM_CH; i++) begin
                m_run[i]  = 0;
                m_lows[i] = 0;
            end
            m_done = '0; m_lost = '0; m_reg = '0; m_dcc = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            lk = raw_hist.pop_front();
            raw_hist.push_back(bus.dll_lock_mux);
            m_reg = lk & ~{NUM_CH{bus.rb_cont_cal}};
            m_dcc = (bus.ch_en != '0) && ((m_done | ~bus.ch_en) == {NUM_CH{1'b1}});
            thr = (bus.rb_lock_dly == 0) ? 1 : int'(bus.rb_lock_dly);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!bus.ch_en[i]) begin
                    m_done[i] = 1'b0;
                    m_run[i]  = 0;
                    m_lows[i] = 0;
                end else begin
                    bit lost_now;
                    lost_now = 1'b0;
                    if (!m_done[i]) begin
                        if (lk[i]) begin
                            m_run[i]++;
                            if (m_run[i] >= thr) begin
                                m_done[i] = 1'b1;
                                m_lows[i] = 0;
                            end
                        end else begin
                            m_run[i] = 0;
                        end
                    end else begin
                        if (lk[i]) begin
                            m_lows[i] = 0;
                        end else begin
                            m_lows[i]++;
                            if (m_lows[i] > int'(bus.rb_unlock_flt)) begin
                                m_done[i] = 1'b0;
                                m_run[i]  = 0;
                                m_lows[i] = 0;
                                lost_now  = 1'b1;
                            end
                        end
                    end
                    if (lost_now) m_lost[i] = 1'b1;
                    else if (bus.clr_lost) m_lost[i] = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_dll_lock_reg", 32'(bus.dll_lock_reg), 32'(m_reg));
            chk("m_ch_done",      32'(bus.ch_done),      32'(m_done));
            chk("m_dcc_done",     32'(bus.dcc_done),     32'(m_dcc));
            chk("m_lock_lost",    32'(bus.lock_lost),    32'(m_lost));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.dll_lock_mux  = '0;
        bus.ch_en         = 4'hF;
        bus.rb_lock_dly   = 8'd8;
        bus.rb_unlock_flt = 4'd3;
        bus.rb_cont_cal   = 1'b0;
        bus.clr_lost      = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("rst_ch_done", 32'(bus.ch_done), 32'h0);
        chk("rst_dcc",     32'(bus.dcc_done), 32'h0);
        chk("rst_lost",    32'(bus.lock_lost), 32'h0);
        rst = 1'b0;
        tick(3);

        // Qualification of all channels, thr=8
        bus.dll_lock_mux = 4'hF;
        tick(2);
        chk("q_reg_e2", 32'(bus.dll_lock_reg), 32'h0);
        tick(1);
        chk("q_reg_e3", 32'(bus.dll_lock_reg), 32'hF);
        tick(6);
        chk("q_done_e9", 32'(bus.ch_done), 32'h0);
        tick(1);
        chk("q_done_e10", 32'(bus.ch_done), 32'hF);
        chk("q_dcc_e10",  32'(bus.dcc_done), 32'h0);
        tick(1);
        chk("q_dcc_e11",  32'(bus.dcc_done), 32'h1);

        // Lose ch0 for real, clear it, then an early drop after 5 high cycles
        bus.dll_lock_mux[0] = 1'b0;
        tick(10);
        chk("ed_lost0", 32'(bus.lock_lost), 32'h1);
        bus.clr_lost = 1'b1;
        tick(1);
        bus.clr_lost = 1'b0;
        chk("ed_clr", 32'(bus.lock_lost), 32'h0);
        bus.dll_lock_mux[0] = 1'b1;
        tick(5);
        bus.dll_lock_mux[0] = 1'b0;
        tick(10);
        chk("ed_done0", 32'(bus.ch_done[0]), 32'h0);
        chk("ed_nolost", 32'(bus.lock_lost), 32'h0);
        bus.dll_lock_mux[0] = 1'b1;
        tick(9);
        chk("ed_re_e9", 32'(bus.ch_done[0]), 32'h0);
        tick(1);
        chk("ed_re_e10", 32'(bus.ch_done[0]), 32'h1);
        tick(1);
        chk("ed_dcc", 32'(bus.dcc_done), 32'h1);

        // Glitch filter on ch1, flt=3
        bus.dll_lock_mux[1] = 1'b0;
        tick(2);
        bus.dll_lock_mux[1] = 1'b1;
        tick(6);
        chk("gl_short_done", 32'(bus.ch_done), 32'hF);
        chk("gl_short_lost", 32'(bus.lock_lost), 32'h0);
        bus.dll_lock_mux[1] = 1'b0;
        tick(4);
        bus.dll_lock_mux[1] = 1'b1;
        tick(1);
        chk("gl_e5_done", 32'(bus.ch_done), 32'hF);
        tick(1);
        chk("gl_e6_done", 32'(bus.ch_done), 32'hD);
        chk("gl_e6_lost", 32'(bus.lock_lost), 32'h2);
        chk("gl_e6_dcc",  32'(bus.dcc_done), 32'h1);
        tick(1);
        chk("gl_e7_dcc",  32'(bus.dcc_done), 32'h0);
        tick(12);
        bus.clr_lost = 1'b1;
        tick(1);
        bus.clr_lost = 1'b0;
        chk("gl_relock", 32'(bus.ch_done), 32'hF);

        // Same-edge set and clear on ch2: set wins
        bus.dll_lock_mux[2] = 1'b0;
        tick(5);
        chk("st_e5_lost", 32'(bus.lock_lost), 32'h0);
        bus.clr_lost = 1'b1;
        tick(1);
        bus.clr_lost = 1'b0;
        chk("st_setwins", 32'(bus.lock_lost), 32'h4);
        chk("st_done",    32'(bus.ch_done), 32'hB);
        bus.clr_lost = 1'b1;
        tick(1);
        bus.clr_lost = 1'b0;
        chk("st_clr", 32'(bus.lock_lost), 32'h0);
        bus.dll_lock_mux[2] = 1'b1;
        tick(12);

        // Masking and enables
        bus.rb_cont_cal = 1'b1;
        tick(1);
        chk("mk_reg",  32'(bus.dll_lock_reg), 32'h0);
        chk("mk_done", 32'(bus.ch_done), 32'hF);
        chk("mk_dcc",  32'(bus.dcc_done), 32'h1);
        bus.rb_cont_cal = 1'b0;
        tick(1);
        chk("mk_unreg", 32'(bus.dll_lock_reg), 32'hF);
        bus.ch_en = 4'b0011;
        bus.dll_lock_mux = 4'b0011;
        tick(2);
        chk("en_done", 32'(bus.ch_done), 32'h3);
        chk("en_dcc",  32'(bus.dcc_done), 32'h1);
        bus.ch_en = 4'b0000;
        tick(1);
        chk("en0_done", 32'(bus.ch_done), 32'h0);
        chk("en0_dcc",  32'(bus.dcc_done), 32'h0);

        // Reset mid-qualification, then thr=0
        bus.ch_en = 4'hF;
        bus.dll_lock_mux = 4'h0;
        tick(4);
        bus.dll_lock_mux = 4'hF;
        tick(6);
        rst = 1'b1;
        tick(1);
        chk("rq_reg",  32'(bus.dll_lock_reg), 32'h0);
        chk("rq_done", 32'(bus.ch_done), 32'h0);
        chk("rq_dcc",  32'(bus.dcc_done), 32'h0);
        rst = 1'b0;
        bus.dll_lock_mux = 4'h0;
        bus.rb_lock_dly = 8'd0;
        tick(4);
        bus.dll_lock_mux = 4'hF;
        tick(2);
        chk("t0_e2", 32'(bus.ch_done), 32'h0);
        tick(1);
        chk("t0_e3", 32'(bus.ch_done), 32'hF);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 160 == 0) begin
                bus.rb_lock_dly   = 8'($urandom_range(0, 12));
                bus.rb_unlock_flt = 4'($urandom_range(0, 5));
                bus.ch_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 9) == 0) bus.dll_lock_mux[i] = ~bus.dll_lock_mux[i];
            end
            bus.clr_lost = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) bus.rb_cont_cal = ~bus.rb_cont_cal;
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
